// File: rtl/setting_ctrl.sv
// Settings menu editor for the quiz game: button edges drive item selection,
// saturating value edits and press-and-hold auto-repeat, active only in view 0.
module setting_ctrl #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] view,
   input  logic       btn_next,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_confirm,
   output logic [2:0] state,
   output logic [2:0] player_count,
   output logic [3:0] question_count,
   output logic [6:0] answer_time,
   output logic [6:0] win_socre,
   output logic [3:0] success_score,
   output logic [3:0] fail_score,
   output logic       settings_done,
   output logic       key_beep,
   output logic       limit_hit
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW      = $clog2(RPT_MAX + 1);
   localparam logic [CW-1:0] DLY_T = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_T = CW'(REPEAT_PERIOD - 1);

   logic          prev_next, prev_up, prev_down, prev_confirm;
   logic          e_next, e_up, e_down, e_confirm, any_edge;
   logic [CW-1:0] rpt_cnt;
   logic          rpt_run, rpt_arm;
   logic [CW-1:0] rpt_tgt;

   logic [7:0] cur, vmin, vmax, step, nv;
   logic       dir_up, in_range;

   assign e_next    = btn_next    & ~prev_next;
   assign e_up      = btn_up      & ~prev_up;
   assign e_down    = btn_down    & ~prev_down;
   assign e_confirm = btn_confirm & ~prev_confirm;
   assign any_edge  = e_next | e_up | e_down | e_confirm;
   assign rpt_tgt   = rpt_run ? PER_T : DLY_T;

   // Operand selection for the item under edit; everything is 8 bits wide so
   // value+step can never overflow before the bound check.
   always_comb begin
      cur  = 8'd0;
      vmin = 8'd0;
      vmax = 8'd0;
      step = 8'd1;
      case (state)
         3'd1: begin cur = {5'd0, player_count};   vmin = 8'd2;  vmax = 8'd4;  end
         3'd2: begin cur = {4'd0, question_count}; vmin = 8'd1;  vmax = 8'd9;  end
         3'd3: begin cur = {1'b0, answer_time};    vmin = 8'd10; vmax = 8'd95; step = 8'd5; end
         3'd4: begin cur = {1'b0, win_socre};      vmin = 8'd5;  vmax = 8'd99; end
         3'd5: begin cur = {4'd0, success_score};  vmin = 8'd1;  vmax = 8'd9;  end
         3'd6: begin cur = {4'd0, fail_score};     vmin = 8'd0;  vmax = 8'd9;  end
         default: ;
      endcase
      // A fresh edge decides direction; otherwise the held level does.
      dir_up = (e_up ^ e_down) ? e_up : btn_up;
      if (dir_up) begin
         nv       = cur + step;
         in_range = (nv <= vmax);
      end else begin
         nv       = cur - step;
         in_range = (cur >= vmin + step);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_next      <= 1'b0;
         prev_up        <= 1'b0;
         prev_down      <= 1'b0;
         prev_confirm   <= 1'b0;
         state          <= 3'd0;
         player_count   <= 3'd2;
         question_count <= 4'd5;
         answer_time    <= 7'd30;
         win_socre      <= 7'd20;
         success_score  <= 4'd2;
         fail_score     <= 4'd1;
         settings_done  <= 1'b0;
         key_beep       <= 1'b0;
         limit_hit      <= 1'b0;
         rpt_cnt        <= '0;
         rpt_run        <= 1'b0;
         rpt_arm        <= 1'b0;
      end else begin
         prev_next     <= btn_next;
         prev_up       <= btn_up;
         prev_down     <= btn_down;
         prev_confirm  <= btn_confirm;
         settings_done <= 1'b0;
         key_beep      <= 1'b0;
         limit_hit     <= 1'b0;

         // Default: drop any repeat in progress; only the held-key path keeps it.
         rpt_cnt <= '0;
         rpt_run <= 1'b0;
         rpt_arm <= 1'b0;

         if (view == 3'd0) begin
            if (e_confirm) begin
               state         <= 3'd0;
               settings_done <= 1'b1;
               key_beep      <= 1'b1;
            end else if (e_next) begin
               state    <= (state == 3'd0 || state == 3'd6) ? 3'd1 : state + 3'd1;
               key_beep <= 1'b1;
            end else if (state != 3'd0 && ((e_up ^ e_down) ||
                         (!any_edge && rpt_arm && (btn_up ^ btn_down) && rpt_cnt == rpt_tgt))) begin
               // Edge step or repeat step: identical saturating edit.
               if (in_range) begin
                  key_beep <= 1'b1;
                  case (state)
                     3'd1: player_count   <= nv[2:0];
                     3'd2: question_count <= nv[3:0];
                     3'd3: answer_time    <= nv[6:0];
                     3'd4: win_socre      <= nv[6:0];
                     3'd5: success_score  <= nv[3:0];
                     3'd6: fail_score     <= nv[3:0];
                     default: ;
                  endcase
               end else begin
                  limit_hit <= 1'b1;
               end
               rpt_arm <= 1'b1;
               rpt_run <= !any_edge;
            end else if (state != 3'd0 && !any_edge && rpt_arm && (btn_up ^ btn_down)) begin
               rpt_arm <= 1'b1;
               rpt_run <= rpt_run;
               rpt_cnt <= rpt_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_setting_ctrl.sv
// Directed bench for setting_ctrl with short repeat timing (delay 20, period 5).
module tb_setting_ctrl;

   localparam logic [3:0] C = 4'b1000, N = 4'b0100, U = 4'b0010, D = 4'b0001;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] view;
   logic [3:0] btn;
   logic [2:0] state;
   logic [2:0] player_count;
   logic [3:0] question_count;
   logic [6:0] answer_time;
   logic [6:0] win_socre;
   logic [3:0] success_score;
   logic [3:0] fail_score;
   logic       settings_done, key_beep, limit_hit;

   int checks = 0;
   int failures = 0;
   int kb, lh, sd;

   setting_ctrl #(.REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
      .clk(clk), .rst(rst), .view(view),
      .btn_next(btn[2]), .btn_up(btn[1]), .btn_down(btn[0]), .btn_confirm(btn[3]),
      .state(state), .player_count(player_count), .question_count(question_count),
      .answer_time(answer_time), .win_socre(win_socre), .success_score(success_score),
      .fail_score(fail_score), .settings_done(settings_done), .key_beep(key_beep),
      .limit_hit(limit_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a button pattern for one cycle, capture the pulses, then release.
   task automatic press(input logic [3:0] b);
      btn = b;
      tick();
      kb = key_beep; lh = limit_hit; sd = settings_done;
      btn = 4'b0;
      tick();
   endtask

   task automatic chk_pulses(input string tag, input int ekb, input int elh, input int esd);
      chk({tag, ".beep"}, kb, ekb);
      chk({tag, ".limit"}, lh, elh);
      chk({tag, ".done"}, sd, esd);
   endtask

   initial begin
      rst = 1'b1; view = 3'd0; btn = 4'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset defaults
      chk("rst.state", state, 0);
      chk("rst.pc", player_count, 2);
      chk("rst.qc", question_count, 5);
      chk("rst.at", answer_time, 30);
      chk("rst.ws", win_socre, 20);
      chk("rst.ss", success_score, 2);
      chk("rst.fs", fail_score, 1);
      chk("rst.pulses", {settings_done, key_beep, limit_hit}, 0);

      // Up at title is ignored
      press(U);
      chk("title_up.state", state, 0);
      chk_pulses("title_up", 0, 0, 0);

      // Navigation 1..6 then wrap to 1
      for (int i = 1; i <= 7; i++) begin
         press(N);
         chk("nav.state", state, (i == 7) ? 1 : i);
         chk("nav.beep", kb, 1);
      end

      // Up+down together at item 1: nothing happens
      press(U | D);
      chk("ud.pc", player_count, 2);
      chk_pulses("ud", 0, 0, 0);

      // Player count upper bound
      press(U); chk("pc.up1", player_count, 3);
      press(U); chk("pc.up2", player_count, 4); chk_pulses("pc.up2", 1, 0, 0);
      press(U); chk("pc.sat", player_count, 4); chk_pulses("pc.sat", 0, 1, 0);

      // Auto-repeat at item 2: 5->6 at edge, 7 @+20, 8 @+25, 9 @+30, limit @+35
      press(N);
      chk("ar.state", state, 2);
      btn = U;
      tick();
      chk("ar.edge", question_count, 6);
      chk("ar.edge.beep", key_beep, 1);
      for (int j = 1; j <= 35; j++) begin
         tick();
         chk($sformatf("ar.qc@%0d", j), question_count,
             (j < 20) ? 6 : (j < 25) ? 7 : (j < 30) ? 8 : 9);
         chk($sformatf("ar.beep@%0d", j), key_beep, (j == 20 || j == 25 || j == 30) ? 1 : 0);
         chk($sformatf("ar.limit@%0d", j), limit_hit, (j == 35) ? 1 : 0);
      end
      btn = 4'b0;
      tick();

      // Answer time: 30 -> 95 in 13 steps, 14th refused; 95 -> 10 in 17, 18th refused
      press(N);
      chk("at.state", state, 3);
      for (int i = 1; i <= 14; i++) begin
         press(U);
         chk("at.up.val", answer_time, (i <= 13) ? 30 + 5 * i : 95);
         chk("at.up.limit", lh, (i == 14) ? 1 : 0);
         chk("at.up.beep", kb, (i == 14) ? 0 : 1);
      end
      for (int i = 1; i <= 18; i++) begin
         press(D);
         chk("at.dn.val", answer_time, (i <= 17) ? 95 - 5 * i : 10);
         chk("at.dn.limit", lh, (i == 18) ? 1 : 0);
      end

      // Confirm+up at item 3: exit, value untouched
      press(C | U);
      chk("cu.state", state, 0);
      chk("cu.at", answer_time, 10);
      chk_pulses("cu", 1, 0, 1);

      // Confirm+next at item 4
      press(N); press(N); press(N); press(N);
      chk("cn.pre", state, 4);
      press(C | N);
      chk("cn.state", state, 0);
      chk_pulses("cn", 1, 0, 1);

      // Fail score lower bound at item 6
      for (int i = 0; i < 6; i++) press(N);
      chk("fs.state", state, 6);
      press(D); chk("fs.dn", fail_score, 0); chk_pulses("fs.dn", 1, 0, 0);
      press(D); chk("fs.sat", fail_score, 0); chk_pulses("fs.sat", 0, 1, 0);

      // View gating
      press(N);
      chk("vg.pre", state, 1);
      view = 3'd2;
      press(N); chk_pulses("vg.n", 0, 0, 0);
      press(U); chk_pulses("vg.u", 0, 0, 0);
      press(D); press(C);
      chk("vg.state", state, 1);
      chk("vg.pc", player_count, 4);
      btn = U;
      tick();
      view = 3'd0;
      for (int j = 0; j < 25; j++) tick();
      chk("vg.held.pc", player_count, 4);
      chk("vg.held.pulses", {key_beep, limit_hit}, 0);
      btn = 4'b0;
      tick();
      press(D);
      chk("vg.after.pc", player_count, 3);
      chk_pulses("vg.after", 1, 0, 0);

      // Reset mid-edit wins over a held button
      btn = U;
      rst = 1'b1;
      tick();
      chk("rst2.state", state, 0);
      chk("rst2.pc", player_count, 2);
      chk("rst2.at", answer_time, 30);
      chk("rst2.fs", fail_score, 1);
      chk("rst2.pulses", {settings_done, key_beep, limit_hit}, 0);
      rst = 1'b0;
      btn = 4'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
